// File: rtl/zion_riscv_isa_lib_int_ex_pkg.sv
// Shared types and constants for the Zion integer execute stage.
package zion_riscv_isa_lib_int_ex_pkg;

   // Unit variants selected by INT_MODULE_TYPE
   localparam int unsigned IntFull  = 0;
   localparam int unsigned IntNoMem = 1;
   localparam int unsigned IntNoBj  = 2;

   // Link increment codes (value is the halfword count, shifted left by one)
   localparam logic [1:0] LinkPlus2 = 2'b01;
   localparam logic [1:0] LinkPlus4 = 2'b10;

   // Register width for the selected base ISA
   function automatic int unsigned xlen(input int unsigned rv64);
      return (rv64 != 0) ? 64 : 32;
   endfunction

   // Decoded control bundle for one integer micro-op
   typedef struct packed {
      logic       add_sub_ins;
      logic       add_en;
      logic       sub_en;
      logic       and_en;
      logic       or_en;
      logic       xor_en;
      logic       sft_left;
      logic       sft_right;
      logic       sft_a;
      logic       slt_en;
      logic       mem_en;
      logic       bj_en;
      logic       branch;
      logic       jump;
      logic       beq;
      logic       bne;
      logic       blt;
      logic       bge;
      logic       flags;
      logic [1:0] link_offset;
   } int_ctrl_t;

endpackage

// File: rtl/zion_riscv_int_cmp.sv
// Signed/unsigned less-than and equality compare for the integer execute stage.
module zion_riscv_int_cmp #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] s1,
   input  logic [XLEN-1:0] s2,
   input  logic            flags,
   output logic            less_than,
   output logic            equal
);

   // flags=1 selects unsigned compare, otherwise signed
   always_comb begin
      less_than = flags ? (s1 < s2) : ($signed(s1) < $signed(s2));
      equal     = (s1 == s2);
   end

endmodule

// File: rtl/zion_riscv_isa_lib_int_ex.sv
// Integer execute stage: ALU result, branch/jump decision and target, memory address.
// All outputs registered with one cycle of latency.
module zion_riscv_isa_lib_int_ex
   import zion_riscv_isa_lib_int_ex_pkg::*;
#(
   parameter int unsigned RV64            = 0,
   parameter int unsigned INT_MODULE_TYPE = 0,
   localparam int unsigned XLEN           = xlen(RV64)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] s1,
   input  logic [XLEN-1:0] s2,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] offset,
   input  logic            flags,
   input  logic            addSubIns,
   input  logic            addEn,
   input  logic            subEn,
   input  logic            andEn,
   input  logic            orEn,
   input  logic            xorEn,
   input  logic            sftLeft,
   input  logic            sftRight,
   input  logic            sftA,
   input  logic            sltEn,
   input  logic            memEn,
   input  logic            bjEn,
   input  logic            branch,
   input  logic            jump,
   input  logic            beq,
   input  logic            bne,
   input  logic            blt,
   input  logic            bge,
   input  logic [1:0]      linkOffset,
   output logic [XLEN-1:0] intRslt,
   output logic [XLEN-1:0] BjTgt,
   output logic            BjEn,
   output logic [XLEN-1:0] memAddr
);

   localparam int unsigned ShW    = (RV64 != 0) ? 6 : 5;
   localparam bit          HasMem = (INT_MODULE_TYPE != IntNoMem);
   localparam bit          HasBj  = (INT_MODULE_TYPE != IntNoBj);

   int_ctrl_t ctrl;
   assign ctrl = '{
      add_sub_ins: addSubIns, add_en: addEn, sub_en: subEn,
      and_en: andEn, or_en: orEn, xor_en: xorEn,
      sft_left: sftLeft, sft_right: sftRight, sft_a: sftA,
      slt_en: sltEn, mem_en: memEn, bj_en: bjEn,
      branch: branch, jump: jump, beq: beq, bne: bne, blt: blt, bge: bge,
      flags: flags, link_offset: linkOffset
   };

   // bjEn is a decode-side group enable; the decision uses the individual controls
   logic unused_bj_en;
   assign unused_bj_en = ctrl.bj_en;

   logic less_than;
   logic equal;

   zion_riscv_int_cmp #(
      .XLEN (XLEN)
   ) u_cmp (
      .s1        (s1),
      .s2        (s2),
      .flags     (ctrl.flags),
      .less_than (less_than),
      .equal     (equal)
   );

   logic [XLEN-1:0] int_rslt_d, bj_tgt_d, mem_addr_d;
   logic            bj_en_d;
   logic [XLEN-1:0] add_sub, bitwise, shift, slt, link;
   logic [ShW-1:0]  sh;

   // Next-state computation; every term is zero when its enable is low
   always_comb begin
      sh = s2[ShW-1:0];

      add_sub = '0;
      if (ctrl.add_sub_ins) begin
         if (ctrl.add_en)      add_sub = s1 + s2;
         else if (ctrl.sub_en) add_sub = s1 - s2;
      end

      bitwise = ({XLEN{ctrl.and_en}} & (s1 & s2)) |
                ({XLEN{ctrl.or_en}}  & (s1 | s2)) |
                ({XLEN{ctrl.xor_en}} & (s1 ^ s2));

      shift = '0;
      if (ctrl.sft_left)                   shift = s1 << sh;
      else if (ctrl.sft_right && ctrl.sft_a) shift = XLEN'($signed(s1) >>> sh);
      else if (ctrl.sft_right)             shift = s1 >> sh;

      slt = {{(XLEN-1){1'b0}}, ctrl.slt_en & less_than};

      link     = '0;
      bj_tgt_d = '0;
      bj_en_d  = 1'b0;
      if (HasBj) begin
         if (ctrl.jump) link = s2 + XLEN'({ctrl.link_offset, 1'b0});
         if (ctrl.jump)        bj_tgt_d = s1 + offset;
         else if (ctrl.branch) bj_tgt_d = pc + offset;
         bj_en_d = ctrl.jump | (ctrl.beq & equal) | (ctrl.bne & ~equal) |
                   (ctrl.blt & less_than) | (ctrl.bge & ~less_than);
      end

      mem_addr_d = (HasMem && ctrl.mem_en) ? (s1 + s2) : '0;

      int_rslt_d = add_sub | bitwise | shift | slt | link;
   end

   logic [XLEN-1:0] int_rslt_q, bj_tgt_q, mem_addr_q;
   logic            bj_en_q;

   // Output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         int_rslt_q <= '0;
         bj_tgt_q   <= '0;
         bj_en_q    <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         int_rslt_q <= int_rslt_d;
         bj_tgt_q   <= bj_tgt_d;
         bj_en_q    <= bj_en_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign intRslt = int_rslt_q;
   assign BjTgt   = bj_tgt_q;
   assign BjEn    = bj_en_q;
   assign memAddr = mem_addr_q;

endmodule

// File: tb/tb_zion_riscv_isa_lib_int_ex.sv
// Directed self-checking bench for the integer execute stage (RV32, all three unit variants).
module tb_zion_riscv_isa_lib_int_ex;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s1, s2, pc, offset;
   logic        flags, addSubIns, addEn, subEn, andEn, orEn, xorEn;
   logic        sftLeft, sftRight, sftA, sltEn, memEn;
   logic        bjEn, branch, jump, beq, bne, blt, bge;
   logic [1:0]  linkOffset;

   logic [31:0] int_rslt0, bj_tgt0, mem_addr0;
   logic [31:0] int_rslt1, bj_tgt1, mem_addr1;
   logic [31:0] int_rslt2, bj_tgt2, mem_addr2;
   logic        bj_en0, bj_en1, bj_en2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   zion_riscv_isa_lib_int_ex #(.RV64(0), .INT_MODULE_TYPE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .pc(pc), .offset(offset), .flags(flags),
      .addSubIns(addSubIns), .addEn(addEn), .subEn(subEn), .andEn(andEn), .orEn(orEn),
      .xorEn(xorEn), .sftLeft(sftLeft), .sftRight(sftRight), .sftA(sftA), .sltEn(sltEn),
      .memEn(memEn), .bjEn(bjEn), .branch(branch), .jump(jump), .beq(beq), .bne(bne),
      .blt(blt), .bge(bge), .linkOffset(linkOffset),
      .intRslt(int_rslt0), .BjTgt(bj_tgt0), .BjEn(bj_en0), .memAddr(mem_addr0));

   zion_riscv_isa_lib_int_ex #(.RV64(0), .INT_MODULE_TYPE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .pc(pc), .offset(offset), .flags(flags),
      .addSubIns(addSubIns), .addEn(addEn), .subEn(subEn), .andEn(andEn), .orEn(orEn),
      .xorEn(xorEn), .sftLeft(sftLeft), .sftRight(sftRight), .sftA(sftA), .sltEn(sltEn),
      .memEn(memEn), .bjEn(bjEn), .branch(branch), .jump(jump), .beq(beq), .bne(bne),
      .blt(blt), .bge(bge), .linkOffset(linkOffset),
      .intRslt(int_rslt1), .BjTgt(bj_tgt1), .BjEn(bj_en1), .memAddr(mem_addr1));

   zion_riscv_isa_lib_int_ex #(.RV64(0), .INT_MODULE_TYPE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .pc(pc), .offset(offset), .flags(flags),
      .addSubIns(addSubIns), .addEn(addEn), .subEn(subEn), .andEn(andEn), .orEn(orEn),
      .xorEn(xorEn), .sftLeft(sftLeft), .sftRight(sftRight), .sftA(sftA), .sltEn(sltEn),
      .memEn(memEn), .bjEn(bjEn), .branch(branch), .jump(jump), .beq(beq), .bne(bne),
      .blt(blt), .bge(bge), .linkOffset(linkOffset),
      .intRslt(int_rslt2), .BjTgt(bj_tgt2), .BjEn(bj_en2), .memAddr(mem_addr2));

   task automatic clear_inputs();
      s1 = '0; s2 = '0; pc = '0; offset = '0; flags = 1'b0;
      addSubIns = 1'b0; addEn = 1'b0; subEn = 1'b0; andEn = 1'b0; orEn = 1'b0; xorEn = 1'b0;
      sftLeft = 1'b0; sftRight = 1'b0; sftA = 1'b0; sltEn = 1'b0; memEn = 1'b0;
      bjEn = 1'b0; branch = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; blt = 1'b0; bge = 1'b0;
      linkOffset = 2'b00;
   endtask

   // Advance one edge and settle before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      addSubIns = 1'b1; addEn = 1'b1; s1 = 32'd7; s2 = 32'd5; memEn = 1'b1;
      jump = 1'b1; offset = 32'h10;
      step(); step();
      checks++;
      if (int_rslt0 !== 32'd0) begin
         errors++; $display("FAIL reset_int: got %h exp %h", int_rslt0, 32'd0);
      end
      checks++;
      if (bj_tgt0 !== 32'd0 || bj_en0 !== 1'b0) begin
         errors++; $display("FAIL reset_bj: got tgt %h en %b exp 0/0", bj_tgt0, bj_en0);
      end
      checks++;
      if (mem_addr0 !== 32'd0) begin
         errors++; $display("FAIL reset_mem: got %h exp %h", mem_addr0, 32'd0);
      end
      clear_inputs();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add_sub();
      clear_inputs();
      addSubIns = 1'b1; addEn = 1'b1; s1 = 32'd7; s2 = 32'd5;
      step();
      checks++;
      if (int_rslt0 !== 32'd12) begin
         errors++; $display("FAIL add: got %h exp %h", int_rslt0, 32'd12);
      end
      clear_inputs();
      addSubIns = 1'b1; subEn = 1'b1; s1 = 32'd3; s2 = 32'd5;
      step();
      checks++;
      if (int_rslt0 !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL sub: got %h exp %h", int_rslt0, 32'hFFFF_FFFE);
      end
      // Enable without addSubIns must contribute nothing
      clear_inputs();
      addEn = 1'b1; s1 = 32'd7; s2 = 32'd5;
      step();
      checks++;
      if (int_rslt0 !== 32'd0) begin
         errors++; $display("FAIL add_gated: got %h exp %h", int_rslt0, 32'd0);
      end
   endtask

   task automatic test_bitwise();
      clear_inputs();
      s1 = 32'hF0F0_1234; s2 = 32'hFF00_00FF;
      andEn = 1'b1; step();
      checks++;
      if (int_rslt0 !== 32'hF000_0034) begin
         errors++; $display("FAIL and: got %h exp %h", int_rslt0, 32'hF000_0034);
      end
      andEn = 1'b0; orEn = 1'b1; step();
      checks++;
      if (int_rslt0 !== 32'hFFF0_12FF) begin
         errors++; $display("FAIL or: got %h exp %h", int_rslt0, 32'hFFF0_12FF);
      end
      orEn = 1'b0; xorEn = 1'b1; step();
      checks++;
      if (int_rslt0 !== 32'h0FF0_12CB) begin
         errors++; $display("FAIL xor: got %h exp %h", int_rslt0, 32'h0FF0_12CB);
      end
   endtask

   task automatic test_shift();
      clear_inputs();
      s1 = 32'h8000_0010; s2 = 32'd4;
      sftLeft = 1'b1; step();
      checks++;
      if (int_rslt0 !== 32'h0000_0100) begin
         errors++; $display("FAIL sll: got %h exp %h", int_rslt0, 32'h0000_0100);
      end
      sftLeft = 1'b0; sftRight = 1'b1; step();
      checks++;
      if (int_rslt0 !== 32'h0800_0001) begin
         errors++; $display("FAIL srl: got %h exp %h", int_rslt0, 32'h0800_0001);
      end
      sftA = 1'b1; step();
      checks++;
      if (int_rslt0 !== 32'hF800_0001) begin
         errors++; $display("FAIL sra: got %h exp %h", int_rslt0, 32'hF800_0001);
      end
      // Only s2[4:0] is the shift amount: 0x24 shifts by 4
      s2 = 32'h24; sftA = 1'b0; sftRight = 1'b0; sftLeft = 1'b1; step();
      checks++;
      if (int_rslt0 !== 32'h0000_0100) begin
         errors++; $display("FAIL sll_mask: got %h exp %h", int_rslt0, 32'h0000_0100);
      end
   endtask

   task automatic test_slt();
      clear_inputs();
      sltEn = 1'b1; s1 = 32'hFFFF_FFFF; s2 = 32'd1; flags = 1'b0;
      step();
      checks++;
      if (int_rslt0 !== 32'd1) begin
         errors++; $display("FAIL slt_signed: got %h exp %h", int_rslt0, 32'd1);
      end
      flags = 1'b1; step();
      checks++;
      if (int_rslt0 !== 32'd0) begin
         errors++; $display("FAIL slt_unsigned: got %h exp %h", int_rslt0, 32'd0);
      end
   endtask

   task automatic test_jump();
      clear_inputs();
      jump = 1'b1; bjEn = 1'b1; s1 = 32'h100; offset = 32'h20; s2 = 32'h200;
      linkOffset = 2'b10;
      step();
      checks++;
      if (bj_tgt0 !== 32'h120 || bj_en0 !== 1'b1) begin
         errors++; $display("FAIL jump_tgt: got tgt %h en %b exp 120/1", bj_tgt0, bj_en0);
      end
      checks++;
      if (int_rslt0 !== 32'h204) begin
         errors++; $display("FAIL jump_link4: got %h exp %h", int_rslt0, 32'h204);
      end
      linkOffset = 2'b01; step();
      checks++;
      if (int_rslt0 !== 32'h202) begin
         errors++; $display("FAIL jump_link2: got %h exp %h", int_rslt0, 32'h202);
      end
      // Variant without branch/jump path
      checks++;
      if (bj_en2 !== 1'b0 || bj_tgt2 !== 32'd0 || int_rslt2 !== 32'd0) begin
         errors++;
         $display("FAIL nobj_jump: got en %b tgt %h rslt %h exp 0/0/0", bj_en2, bj_tgt2, int_rslt2);
      end
   endtask

   task automatic test_branch();
      clear_inputs();
      branch = 1'b1; bjEn = 1'b1; pc = 32'h40; offset = 32'd8; s1 = 32'd9; s2 = 32'd9;
      beq = 1'b1; step();
      checks++;
      if (bj_en0 !== 1'b1 || bj_tgt0 !== 32'h48) begin
         errors++; $display("FAIL beq: got en %b tgt %h exp 1/48", bj_en0, bj_tgt0);
      end
      checks++;
      if (int_rslt0 !== 32'd0) begin
         errors++; $display("FAIL beq_rslt: got %h exp %h", int_rslt0, 32'd0);
      end
      beq = 1'b0; bne = 1'b1; step();
      checks++;
      if (bj_en0 !== 1'b0 || bj_tgt0 !== 32'h48) begin
         errors++; $display("FAIL bne: got en %b tgt %h exp 0/48", bj_en0, bj_tgt0);
      end
      bne = 1'b0; blt = 1'b1; s1 = 32'hFFFF_FFFF; s2 = 32'd1; flags = 1'b0; step();
      checks++;
      if (bj_en0 !== 1'b1) begin
         errors++; $display("FAIL blt_signed: got %b exp %b", bj_en0, 1'b1);
      end
      blt = 1'b0; bge = 1'b1; step();
      checks++;
      if (bj_en0 !== 1'b0) begin
         errors++; $display("FAIL bge_signed: got %b exp %b", bj_en0, 1'b0);
      end
      flags = 1'b1; step();
      checks++;
      if (bj_en0 !== 1'b1) begin
         errors++; $display("FAIL bge_unsigned: got %b exp %b", bj_en0, 1'b1);
      end
   endtask

   task automatic test_mem();
      clear_inputs();
      memEn = 1'b1; s1 = 32'h1000; s2 = 32'd4;
      step();
      checks++;
      if (mem_addr0 !== 32'h1004) begin
         errors++; $display("FAIL mem_addr: got %h exp %h", mem_addr0, 32'h1004);
      end
      checks++;
      if (int_rslt0 !== 32'd0) begin
         errors++; $display("FAIL mem_rslt: got %h exp %h", int_rslt0, 32'd0);
      end
      checks++;
      if (mem_addr1 !== 32'd0) begin
         errors++; $display("FAIL nomem_addr: got %h exp %h", mem_addr1, 32'd0);
      end
      checks++;
      if (mem_addr2 !== 32'h1004) begin
         errors++; $display("FAIL nobj_mem_addr: got %h exp %h", mem_addr2, 32'h1004);
      end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      addSubIns = 1'b1; addEn = 1'b1; s1 = 32'd100; s2 = 32'd23;
      step();
      checks++;
      if (int_rslt0 !== 32'd123) begin
         errors++; $display("FAIL b2b_first: got %h exp %h", int_rslt0, 32'd123);
      end
      clear_inputs();
      step();
      checks++;
      if (int_rslt0 !== 32'd0 || bj_en0 !== 1'b0 || bj_tgt0 !== 32'd0 || mem_addr0 !== 32'd0) begin
         errors++;
         $display("FAIL b2b_idle: got %h %b %h %h exp all 0", int_rslt0, bj_en0, bj_tgt0, mem_addr0);
      end
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      addSubIns = 1'b1; addEn = 1'b1; s1 = 32'd7; s2 = 32'd5;
      memEn = 1'b1; branch = 1'b1; beq = 1'b1; pc = 32'h40; offset = 32'd8;
      step();
      checks++;
      if (int_rslt0 !== 32'd12 || mem_addr0 !== 32'd12) begin
         errors++; $display("FAIL pre_reset: got %h %h exp 0c/0c", int_rslt0, mem_addr0);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if (int_rslt0 !== 32'd0 || bj_en0 !== 1'b0 || bj_tgt0 !== 32'd0 || mem_addr0 !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset: got %h %b %h %h exp all 0", int_rslt0, bj_en0, bj_tgt0, mem_addr0);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (int_rslt0 !== 32'd12 || bj_tgt0 !== 32'h48) begin
         errors++; $display("FAIL post_reset: got %h %h exp 0c/48", int_rslt0, bj_tgt0);
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_add_sub();
      test_bitwise();
      test_shift();
      test_slt();
      test_jump();
      test_branch();
      test_mem();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/zion_riscv_isa_lib_int_ex.md
# zion_riscv_isa_lib_int_ex

Integer execute stage of the Zion RISC-V core library (RV32I/RV64I). It takes decoded integer micro-op enables plus operands and produces the ALU result, branch/jump target and decision, and load/store address. All outputs are registered, with one-cycle latency. It sits between the decode/operand-read stage and writeback/LSU.

## Interface
Parameters:
- RV64, default 0: 0 selects RV32 and 1 selects RV64. XLEN = 32*(RV64+1).
- INT_MODULE_TYPE, default 0: 0 is the full unit; 1 removes the memory-address path; 2 removes the branch/jump path.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- s1, s2  in  XLEN  source operands. s2 carries the PC for jump-link.
- pc  in  XLEN  instruction PC for branch targets
- offset  in  XLEN  sign-extended immediate for branch/jump targets
- flags  in  1  compare mode: 1 is unsigned, 0 is signed
- addSubIns, addEn, subEn  in  1  add/sub result enables
- andEn, orEn, xorEn  in  1  bitwise ops
- sftLeft, sftRight, sftA  in  1  shifts. sftA with sftRight selects arithmetic shift right.
- sltEn  in  1  set-less-than
- memEn  in  1  memory-address calculation
- bjEn, branch, jump, beq, bne, blt, bge  in  1  branch/jump controls
- linkOffset  in  2  link increment code: 01 means +2, 10 means +4
- intRslt  out  XLEN  integer result
- BjTgt  out  XLEN  branch/jump target
- BjEn  out  1  branch taken / jump
- memAddr  out  XLEN  load/store effective address

## Operation
All arithmetic is modulo 2^XLEN. Enables within a group are one-hot. Result terms are ORed; inactive terms contribute 0.
- Add/sub term: active only when addSubIns=1. s1+s2 if addEn, otherwise s1-s2 if subEn.
- Bitwise term: s1&s2, s1|s2 or s1^s2, selected by andEn, orEn, xorEn.
- Shift amount: s2[4:0] for RV32, s2[5:0] for RV64.
  - sftLeft gives s1<<sh.
  - sftRight with sftA=0 gives logical right shift.
  - sftRight with sftA=1 gives arithmetic right shift.
- Compare: LessThan is unsigned s1<s2 when flags=1, otherwise signed. equal is s1==s2.
- SLT term: when sltEn=1, the result is zero-extended LessThan (value 0 or 1).
- Link term: when jump=1, s2 + {linkOffset,1'b0}.
- BjEn = jump | (beq&equal) | (bne&~equal) | (blt&LessThan) | (bge&~LessThan).
- BjTgt:
  - s1+offset when jump (no LSB clear).
  - pc+offset when branch.
  - 0 otherwise.
- memAddr = s1+s2 when memEn, otherwise 0. intRslt does not include memAddr; it is 0 for a pure memEn op.
- INT_MODULE_TYPE=1: memAddr is tied to 0.
- INT_MODULE_TYPE=2: BjEn, BjTgt and the link term are tied to 0.
- With all enables low, every output computes to 0.

## Timing
- All outputs are registered on the rising edge of clk, with latency 1. Values sampled at edge N are visible just after edge N.
- Reset: while rst_n=0 at a rising edge, intRslt, BjTgt, BjEn and memAddr load 0. Results resume at the first edge with rst_n=1.
- No handshake, no stall. A new operation is accepted every cycle.

## Structure
- Shared package holds:
  - the XLEN function of RV64;
  - INT_MODULE_TYPE constants (FULL=0, NO_MEM=1, NO_BJ=2);
  - linkOffset codes;
  - a packed struct for the input control bundle.
- One sub-module, zion_riscv_int_cmp, produces LessThan and equal from s1, s2 and flags.

## Test plan
All cases use RV32 unless noted.
- Add: addSubIns=addEn=1, s1=7, s2=5, giving intRslt=12 next edge. Sub with subEn=1, s1=3, s2=5, giving 0xFFFFFFFE.
- Shifts: s1=0x80000010, s2=4.
  - Left shift gives 0x00000100.
  - Logical right gives 0x08000001.
  - Arithmetic right gives 0xF8000001.
- Compare: sltEn=1, s1=0xFFFFFFFF, s2=1. flags=0 gives intRslt=1; flags=1 gives 0.
- Jump, INT_MODULE_TYPE=0: jump=1, bjEn=1, s1=0x100, offset=0x20, s2=0x200, linkOffset=10.
  - Response: BjTgt=0x120, BjEn=1, intRslt=0x204.
  - With linkOffset=01, intRslt=0x202.
- Branches: pc=0x40, offset=8, s1=s2=9. beq gives BjEn=1, BjTgt=0x48. bne with the same operands gives BjEn=0, BjTgt=0x48.
- Memory address: memEn=1, s1=0x1000, s2=4, giving memAddr=0x1004.
  - INT_MODULE_TYPE=1: memAddr=0.
  - INT_MODULE_TYPE=2 with jump=1: BjEn=0, BjTgt=0, intRslt=0.
- Reset: assert rst_n=0 mid-stream. All outputs are 0 after the next edge.
